// File: rtl/imem_fetch_arbiter.sv
// Round-robin arbiter that shares one combinational-read instruction memory
// between NCORES fetch requesters; the response is registered one cycle after the grant.
module imem_fetch_arbiter #(
    parameter int unsigned Isize  = 32,
    parameter int unsigned NCORES = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NCORES-1:0]         req,
    input  logic [NCORES*Isize-1:0]   addr,
    output logic [NCORES-1:0]         ack,
    output logic [Isize-1:0]          instr,
    output logic                      err,
    output logic [Isize-1:0]          mem_addr,
    input  logic [Isize-1:0]          mem_instr
);

    localparam int unsigned PW = (NCORES > 1) ? $clog2(NCORES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [NCORES-1:0]   ack_q, ack_d;
    logic [Isize-1:0]    instr_q, instr_d;
    logic                err_q, err_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;

    logic [NCORES-1:0]   elig;
    logic [PW-1:0]       win;
    logic                found;
    logic [Isize-1:0]    sel_addr;

    // A core acked this cycle is masked so a held req is not served twice in a row.
    always_comb begin
        elig = req;
        if (state_q == RESP) begin
            elig = req & ~ack_q;
        end
    end

    // Scan from rr_ptr upward, wrapping at NCORES; the first eligible core wins.
    always_comb begin : pick
        logic [PW:0] slot;
        found = 1'b0;
        win   = '0;
        slot  = '0;
        for (int unsigned k = 0; k < NCORES; k++) begin
            slot = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (slot >= (PW+1)'(NCORES)) begin
                slot = slot - (PW+1)'(NCORES);
            end
            if (!found && elig[slot[PW-1:0]]) begin
                found = 1'b1;
                win   = slot[PW-1:0];
            end
        end
    end

    always_comb begin
        sel_addr = addr[win*Isize +: Isize];
        mem_addr = '0;
        if (found && !reset) begin
            mem_addr = sel_addr;
        end
    end

    always_comb begin
        state_d  = IDLE;
        ack_d    = '0;
        instr_d  = instr_q;
        err_d    = 1'b0;
        rr_ptr_d = rr_ptr_q;
        if (found) begin
            state_d      = RESP;
            ack_d[win]   = 1'b1;
            instr_d      = mem_instr;
            err_d        = |sel_addr[1:0];
            rr_ptr_d     = (win == PW'(NCORES-1)) ? '0 : win + PW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ack_q    <= '0;
            instr_q  <= '0;
            err_q    <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            instr_q  <= instr_d;
            err_q    <= err_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign ack   = ack_q;
    assign instr = instr_q;
    assign err   = err_q;

    a_ack_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(ack_q));
    a_state_ack:  assert property (@(posedge clock) disable iff (reset)
                                   (state_q == RESP) == (ack_q != '0));

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Bench for imem_fetch_arbiter: directed scenarios plus random traffic checked
// against a cycle-level behavioural model of the arbitration rules.
module tb_imem_fetch_arbiter;

    localparam int NC = 2;
    localparam int IS = 32;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NC-1:0]      req   = '0;
    logic [NC*IS-1:0]   addr  = '0;
    logic [NC-1:0]      ack;
    logic [IS-1:0]      instr;
    logic               err;
    logic [IS-1:0]      mem_addr;
    logic [IS-1:0]      mem_instr;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_win   = -1;
    int          m_ptr   = 0;
    logic [31:0] m_instr = '0;
    logic        m_err   = 1'b0;
    int          losses [NC];
    int          max_loss = 0;

    imem_fetch_arbiter #(.Isize(IS), .NCORES(NC)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .addr      (addr),
        .ack       (ack),
        .instr     (instr),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_instr (mem_instr)
    );

    always #5 clock = ~clock;

    // Memory: word k holds A000_0000 + k
    assign mem_instr = 32'hA000_0000 + {2'b00, mem_addr[31:2]};

    function automatic logic [NC*IS-1:0] pack(input logic [31:0] a1, input logic [31:0] a0);
        return {a1, a0};
    endfunction

    task automatic model_reset();
        m_win   = -1;
        m_ptr   = 0;
        m_instr = '0;
        m_err   = 1'b0;
        for (int c = 0; c < NC; c++) losses[c] = 0;
    endtask

    // Entered and left at posedge+1. Drives one cycle of inputs and checks both
    // the combinational memory address and the registered response.
    task automatic cycle(input logic [NC-1:0] r, input logic [NC*IS-1:0] a, input string tag);
        logic [NC-1:0] prev, e, exp_ack;
        logic [IS-1:0] exp_ma;
        int w;
        req  = r;
        addr = a;
        #1;
        prev = (m_win >= 0) ? (NC'(1) << m_win) : '0;
        e    = r & ~prev;
        w    = -1;
        for (int k = 0; k < NC; k++) begin
            if (w < 0 && e[(m_ptr + k) % NC]) w = (m_ptr + k) % NC;
        end
        exp_ma = '0;
        if (w >= 0) exp_ma = a[w*IS +: IS];
        checks++;
        if (mem_addr !== exp_ma) begin
            errors++;
            $display("FAIL %s mem_addr got %h exp %h", tag, mem_addr, exp_ma);
        end
        for (int c = 0; c < NC; c++) begin
            if (!r[c]) losses[c] = 0;
            else if (w == c) losses[c] = 0;
            else if (e[c]) begin
                losses[c]++;
                if (losses[c] > max_loss) max_loss = losses[c];
            end
        end
        @(posedge clock);
        #1;
        if (w >= 0) begin
            m_instr = 32'hA000_0000 + (exp_ma >> 2);
            m_err   = (exp_ma[1:0] != 2'b00);
            m_ptr   = (w + 1) % NC;
        end else begin
            m_err = 1'b0;
        end
        m_win   = w;
        exp_ack = (w >= 0) ? (NC'(1) << w) : '0;
        checks++;
        if (ack !== exp_ack) begin
            errors++;
            $display("FAIL %s ack got %b exp %b", tag, ack, exp_ack);
        end
        checks++;
        if (instr !== m_instr) begin
            errors++;
            $display("FAIL %s instr got %h exp %h", tag, instr, m_instr);
        end
        checks++;
        if (err !== m_err) begin
            errors++;
            $display("FAIL %s err got %b exp %b", tag, err, m_err);
        end
    endtask

    // Asserts reset mid-cycle (from posedge+1) with r_hold requesting; releases at a later posedge+1.
    task automatic apply_reset(input logic [NC-1:0] r_hold, input string tag);
        req  = r_hold;
        addr = pack(32'h44, 32'h1C);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (ack !== '0 || instr !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL %s async clear got ack=%b instr=%h err=%b exp 0/0/0", tag, ack, instr, err);
        end
        checks++;
        if (mem_addr !== '0) begin
            errors++;
            $display("FAIL %s mem_addr in reset got %h exp 0", tag, mem_addr);
        end
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clock);
        #1;
        apply_reset('0, "reset");
    endtask

    task automatic test_single();
        cycle(2'b01, pack(32'h0, 32'h10), "single_req");
        checks++;
        if (ack !== 2'b01 || instr !== 32'hA000_0004 || err !== 1'b0) begin
            errors++;
            $display("FAIL single_lit got ack=%b instr=%h err=%b exp 01/A0000004/0", ack, instr, err);
        end
        cycle(2'b00, pack(32'h0, 32'h10), "single_drop");
        checks++;
        if (ack !== 2'b00) begin
            errors++;
            $display("FAIL single_idle ack got %b exp 00", ack);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset('0, "b2b_reset");
        for (int i = 0; i < 8; i++) begin
            cycle(2'b11, pack(32'h8, 32'h0), "b2b");
            checks++;
            if (ack !== ((i % 2 == 0) ? 2'b01 : 2'b10) ||
                instr !== ((i % 2 == 0) ? 32'hA000_0000 : 32'hA000_0002)) begin
                errors++;
                $display("FAIL b2b_lit[%0d] got ack=%b instr=%h", i, ack, instr);
            end
        end
    endtask

    task automatic test_misaligned();
        cycle(2'b00, pack(32'h6, 32'h0), "mis_idle");
        cycle(2'b10, pack(32'h6, 32'h0), "misaligned");
        checks++;
        if (ack !== 2'b10 || err !== 1'b1 || instr !== 32'hA000_0001) begin
            errors++;
            $display("FAIL mis_lit got ack=%b err=%b instr=%h exp 10/1/A0000001", ack, err, instr);
        end
        cycle(2'b00, pack(32'h6, 32'h0), "mis_after");
    endtask

    task automatic test_withdraw();
        apply_reset('0, "wd_reset");
        cycle(2'b01, pack(32'h0, 32'h20), "wd_prime");
        cycle(2'b00, pack(32'h0, 32'h20), "wd_gap");
        cycle(2'b11, pack(32'h40, 32'h30), "wd_core1_wins");
        checks++;
        if (ack !== 2'b10) begin
            errors++;
            $display("FAIL wd_win ack got %b exp 10", ack);
        end
        cycle(2'b10, pack(32'h40, 32'h30), "wd_drop");
        checks++;
        if (ack !== 2'b00) begin
            errors++;
            $display("FAIL wd_noack ack got %b exp 00", ack);
        end
    endtask

    task automatic test_reset_mid();
        cycle(2'b10, pack(32'h14, 32'h0), "rm_win");
        checks++;
        if (ack !== 2'b10) begin
            errors++;
            $display("FAIL rm_pre ack got %b exp 10", ack);
        end
        apply_reset(2'b10, "rm_reset");
        cycle(2'b10, pack(32'h18, 32'h0), "rm_release");
        checks++;
        if (ack !== 2'b10 || instr !== 32'hA000_0006) begin
            errors++;
            $display("FAIL rm_post got ack=%b instr=%h exp 10/A0000006", ack, instr);
        end
    endtask

    task automatic test_continuous();
        logic [31:0] a0;
        int n_ack;
        cycle(2'b00, '0, "cont_idle");
        a0 = 32'h100;
        n_ack = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(2'b01, pack(32'h0, a0), "cont");
            if (ack[0]) begin
                n_ack++;
                a0 = {$urandom_range(0, 1023), 2'b00};
            end
        end
        checks++;
        if (n_ack != 5) begin
            errors++;
            $display("FAIL cont_rate acks got %0d exp 5", n_ack);
        end
    endtask

    task automatic test_random();
        logic [NC-1:0] r;
        logic [31:0] a0, a1;
        apply_reset('0, "rnd_reset");
        max_loss = 0;
        for (int i = 0; i < 400; i++) begin
            r  = NC'($urandom);
            a0 = $urandom;
            a1 = $urandom;
            if (i >= 200) r = 2'b11;
            cycle(r, pack(a1, a0), "random");
        end
        checks++;
        if (max_loss > NC - 1) begin
            errors++;
            $display("FAIL fairness max losses got %0d exp <= %0d", max_loss, NC - 1);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_misaligned();
        test_withdraw();
        test_reset_mid();
        test_continuous();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
